// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-stage constants: exception vector layout and common types.
package if_fetch_queue_pkg;
    localparam int EXCEPTION_TYPE_WIDTH = 20;
    localparam int INT_ECODE            = 0;
    localparam int ADEF_LOCATION        = 6;

    typedef logic [31:0] pc_t;
endpackage

// File: rtl/if_fetch_queue_if.sv
// Bundles the preif request, instruction-memory and IF->ID signals of the fetch queue.
interface if_fetch_queue_if
    import if_fetch_queue_pkg::*;
#(
    parameter int FETCH_W = 1,
    parameter int EXC_W   = EXCEPTION_TYPE_WIDTH
) ();
    logic                   flush_i;
    logic                   req_valid_i;
    logic                   req_ready_o;
    pc_t                    req_pc_i;
    logic                   req_excep_en_i;
    logic [EXC_W-1:0]       req_excep_type_i;
    logic                   inst_req_o;
    pc_t                    inst_addr_o;
    logic                   inst_addr_ok_i;
    logic                   inst_data_ok_i;
    logic [FETCH_W*32-1:0]  inst_rdata_i;
    logic                   interrupt_en_i;
    logic                   id_allowin_i;
    logic                   id_valid_o;
    pc_t                    id_pc_o;
    logic [FETCH_W*32-1:0]  id_inst_o;
    logic [FETCH_W-1:0]     id_slot_mask_o;
    logic                   id_excep_en_o;
    logic [EXC_W-1:0]       id_excep_type_o;

    modport slave (
        input  flush_i, req_valid_i, req_pc_i, req_excep_en_i, req_excep_type_i,
               inst_addr_ok_i, inst_data_ok_i, inst_rdata_i, interrupt_en_i, id_allowin_i,
        output req_ready_o, inst_req_o, inst_addr_o, id_valid_o, id_pc_o, id_inst_o,
               id_slot_mask_o, id_excep_en_o, id_excep_type_o
    );

    modport master (
        output flush_i, req_valid_i, req_pc_i, req_excep_en_i, req_excep_type_i,
               inst_addr_ok_i, inst_data_ok_i, inst_rdata_i, interrupt_en_i, id_allowin_i,
        input  req_ready_o, inst_req_o, inst_addr_o, id_valid_o, id_pc_o, id_inst_o,
               id_slot_mask_o, id_excep_en_o, id_excep_type_o
    );
endinterface

// File: rtl/if_pend_fifo.sv
// Small index FIFO holding queue slots awaiting an in-order memory response.
// Head visible combinationally; no full/empty flags, the caller bounds occupancy.
module if_pend_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        rd_d = rd_q;
        wr_d = wr_q;
        if (clr_i) begin
            rd_d = '0;
            wr_d = '0;
        end else begin
            if (push_i) wr_d = nxt(wr_q);
            if (pop_i)  rd_d = nxt(rd_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            wr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            if (push_i && !clr_i) mem_q[wr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_q];
endmodule

// File: rtl/if_fetch_queue.sv
// IF fetch queue: in-order buffer between preif/memory and ID; data_ok -> id_valid next cycle.
// Backpressure: req_ready drops when the queue is full or MAX_OUT responses are outstanding.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int FETCH_W = 1,
    parameter int EXC_W   = EXCEPTION_TYPE_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_queue_if.slave bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(MAX_OUT + 1);
    localparam int IW   = FETCH_W * 32;

    logic             valid_q [DEPTH];
    logic             done_q  [DEPTH];
    logic             exc_q   [DEPTH];
    logic [EXC_W-1:0] type_q  [DEPTH];
    pc_t              pc_q    [DEPTH];
    logic [IW-1:0]    inst_q  [DEPTH];

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_idx;
    logic [CNTW-1:0]  count_q, count_d;
    logic [CW-1:0]    inflight_q, inflight_d, cancel_q, cancel_d;

    logic             misalign, exc, room, accept, issue, live_ok, drop_ok, any_ok, pop;
    logic [EXC_W-1:0] exc_type, head_type;
    logic [FETCH_W-1:0] mask_w;

    always_comb begin
        misalign = bus.req_pc_i[1:0] != 2'b00;
        exc      = bus.req_excep_en_i | misalign;
        exc_type = bus.req_excep_type_i;
        exc_type[ADEF_LOCATION] = exc_type[ADEF_LOCATION] | misalign;
        room     = (count_q < CNTW'(DEPTH))
                && (({1'b0, inflight_q} + {1'b0, cancel_q}) < (CW + 1)'(MAX_OUT))
                && !bus.flush_i;
    end

    assign bus.inst_req_o  = bus.req_valid_i & room & !exc;
    assign bus.req_ready_o = room & (exc | bus.inst_addr_ok_i);
    assign bus.inst_addr_o = bus.req_pc_i;

    assign accept  = bus.req_valid_i & bus.req_ready_o;
    assign issue   = accept & !exc;
    // Responses still owed to cancelled requests are consumed before live ones.
    assign live_ok = bus.inst_data_ok_i && cancel_q == '0 && inflight_q != '0;
    assign drop_ok = bus.inst_data_ok_i && cancel_q != '0;
    assign any_ok  = live_ok | drop_ok;
    assign pop     = bus.id_valid_o & bus.id_allowin_i;

    always_comb begin
        if (bus.flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = '0;
            cancel_d   = cancel_q + inflight_q - CW'(any_ok);
        end else begin
            head_d     = head_q + PW'(pop);
            tail_d     = tail_q + PW'(accept);
            count_d    = count_q + CNTW'(accept) - CNTW'(pop);
            inflight_d = inflight_q + CW'(issue) - CW'(live_ok);
            cancel_d   = cancel_q - CW'(drop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            cancel_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            cancel_q   <= cancel_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
                exc_q[i]   <= 1'b0;
                type_q[i]  <= '0;
                pc_q[i]    <= '0;
                inst_q[i]  <= '0;
            end
        end else if (bus.flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
            end
        end else begin
            // Exception entries complete at allocation and carry no instruction.
            if (accept) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= exc;
                exc_q[tail_q]   <= exc;
                type_q[tail_q]  <= exc ? exc_type : '0;
                pc_q[tail_q]    <= bus.req_pc_i;
                inst_q[tail_q]  <= '0;
            end
            if (live_ok) begin
                done_q[fill_idx] <= 1'b1;
                inst_q[fill_idx] <= bus.inst_rdata_i;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
        end
    end

    if_pend_fifo #(.DEPTH(MAX_OUT), .W(PW)) u_pend (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (bus.flush_i),
        .push_i     (issue),
        .push_dat_i (tail_q),
        .pop_i      (live_ok),
        .head_dat_o (fill_idx)
    );

    generate
        if (FETCH_W == 2) begin : g_pair
            assign mask_w = pc_q[head_q][2] ? 2'b10 : 2'b11;
        end else begin : g_single
            assign mask_w = '1;
        end
    endgenerate

    always_comb begin
        head_type = type_q[head_q];
        head_type[INT_ECODE] = head_type[INT_ECODE] | bus.interrupt_en_i;
    end

    assign bus.id_valid_o      = valid_q[head_q] & done_q[head_q] & !bus.flush_i;
    assign bus.id_pc_o         = pc_q[head_q];
    assign bus.id_inst_o       = inst_q[head_q];
    assign bus.id_slot_mask_o  = bus.id_valid_o ? mask_w : '0;
    assign bus.id_excep_en_o   = bus.id_valid_o & (exc_q[head_q] | bus.interrupt_en_i);
    assign bus.id_excep_type_o = bus.id_valid_o ? head_type : '0;

    data_ok_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.inst_data_ok_i && inflight_q == '0 && cancel_q == '0));
endmodule
